// File: rtl/button_conditioner.sv
// button_conditioner
//   Push-button front end for the clock design: synchronises raw active-low
//   buttons, debounces them on a shared slow sample tick and emits one-CLK
//   press pulses for the clock core (clr, minup, secup).
//
//   Optional feature: define AUTO_REPEAT_EN to add auto-repeat pulses while a
//   button stays held. Without it there is exactly one pulse per press.
//
// Ports
//   CLK     in   1     system clock
//   RST     in   1     synchronous, active-high reset
//   nBIN    in   NBTN  raw buttons, active-low, asynchronous to CLK
//   BOUT    out  NBTN  one-CLK pulse per accepted press (and per repeat)
//   BLEVEL  out  NBTN  debounced level, 1 = pressed
module button_conditioner #(
  parameter int NBTN         = 3,
  parameter int SAMPLE_DIV   = 250000,
  parameter int STABLE_N     = 4,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 40
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] nBIN,
  output logic [NBTN-1:0] BOUT,
  output logic [NBTN-1:0] BLEVEL
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;

  logic [NBTN-1:0] s1, s2;
  logic [DW-1:0]   divcnt;
  logic            tick;
  logic [SW-1:0]   scnt [NBTN];
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] fire;

  // Two-flop synchroniser; inversion makes 1 = pressed from here on.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ~nBIN;
      s2 <= s1;
    end
  end

  // Free-running sample divider shared by all buttons.
  assign tick = (divcnt == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST)
      divcnt <= '0;
    else if (tick)
      divcnt <= '0;
    else
      divcnt <= divcnt + DW'(1);
  end

  // Debounce: level flips only after STABLE_N consecutive disagreeing ticks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BLEVEL <= '0;
      for (int unsigned i = 0; i < NBTN; i++)
        scnt[i] <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (s2[i] == BLEVEL[i]) begin
          scnt[i] <= '0;
        end else if (scnt[i] == SW'(STABLE_N - 1)) begin
          BLEVEL[i] <= s2[i];
          scnt[i]   <= '0;
        end else begin
          scnt[i] <= scnt[i] + SW'(1);
        end
      end
    end
  end

  // Press decode mirrors the 0->1 update above so the registered pulse lands
  // on the same edge as the level change.
  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < NBTN; i++)
      press[i] = tick && s2[i] && !BLEVEL[i] && (scnt[i] == SW'(STABLE_N - 1));
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  logic [RW-1:0]   rcnt [NBTN];
  logic [NBTN-1:0] rpt;

  // rcnt reloads to DELAY-RATE after each repeat so later repeats come every
  // RATE ticks while the count never exceeds DELAY-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NBTN; i++)
        rcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (!BLEVEL[i])
          rcnt[i] <= '0;
        else if (tick) begin
          if (rcnt[i] == RW'(REPEAT_DELAY - 1))
            rcnt[i] <= RW'(REPEAT_DELAY - REPEAT_RATE);
          else
            rcnt[i] <= rcnt[i] + RW'(1);
        end
      end
    end
  end

  always_comb begin
    rpt = '0;
    for (int unsigned i = 0; i < NBTN; i++)
      rpt[i] = tick && BLEVEL[i] && (rcnt[i] == RW'(REPEAT_DELAY - 1));
  end

  assign fire = press | rpt;
`else
  assign fire = press;
`endif

  always_ff @(posedge CLK) begin
    if (RST)
      BOUT <= '0;
    else
      BOUT <= fire;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Self-checking bench for button_conditioner with SAMPLE_DIV=4, STABLE_N=3,
//   REPEAT_DELAY=8, REPEAT_RATE=2. Directed vectors plus randomized stimulus
//   against a behavioural reference model. Works with or without
//   AUTO_REPEAT_EN defined.
module tb_button_conditioner;

  localparam int SD = 4;
  localparam int SN = 3;
  localparam int RD = 8;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] nbin = 3'b111;
  logic [2:0] bout, blevel;

  button_conditioner #(
    .NBTN(3), .SAMPLE_DIV(SD), .STABLE_N(SN),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLK(clk), .RST(rst), .nBIN(nbin), .BOUT(bout), .BLEVEL(blevel)
  );

  always #5 clk = ~clk;

  int npass  = 0;
  int ntotal = 0;
  int ecyc   = 0;

  // Reference model state: a press sample reaches the debouncer two edges
  // after it is taken; the tick falls on every SD-th edge after reset.
  logic [2:0] m_h1, m_h2, m_lvl, m_bout;
  int         m_run [3];
  int         m_t   [3];
  int         m_ecount;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    ntotal++;
    if (act === exp)
      npass++;
    else
      $display("FAIL %s at edge %0d t=%0t: got %b expected %b", name, ecyc, $time, act, exp);
  endtask

  task automatic model_update();
    logic [2:0] samp;
    bit         tk;
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_lvl = '0; m_bout = '0; m_ecount = 0;
      for (int unsigned i = 0; i < 3; i++) begin
        m_run[i] = 0;
        m_t[i]   = 0;
      end
    end else begin
      samp = m_h2;
      tk   = ((m_ecount % SD) == SD - 1);
      m_ecount++;
      m_bout = '0;
      for (int unsigned i = 0; i < 3; i++) begin
        if (tk) begin
`ifdef AUTO_REPEAT_EN
          if (m_lvl[i]) begin
            m_t[i]++;
            if (m_t[i] >= RD && ((m_t[i] - RD) % RR) == 0)
              m_bout[i] = 1'b1;
          end
`endif
          if (samp[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == SN) begin
              m_lvl[i] = samp[i];
              m_run[i] = 0;
              if (samp[i]) begin
                m_bout[i] = 1'b1;
                m_t[i]    = 0;
              end
            end
          end else begin
            m_run[i] = 0;
          end
        end
        if (!m_lvl[i])
          m_t[i] = 0;
      end
      m_h2 = m_h1;
      m_h1 = ~nbin;
    end
  endtask

  // One clock edge: predict, clock, then compare shortly after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (rst) ecyc = 0;
    else     ecyc++;
    chk("model_bout", bout, m_bout);
    chk("model_blevel", blevel, m_lvl);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    nbin = 3'b111;
    for (int unsigned k = 0; k < 3; k++) step();
    chk("reset_bout", bout, 3'b000);
    chk("reset_blevel", blevel, 3'b000);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] nbin;
    logic [2:0] bout;
    logic [2:0] blevel;
  } vec_t;

  vec_t tv [1:16];

  logic [2:0] exp_b;
  int hold   [3];
  logic [2:0] rnd;

  initial begin
    for (int unsigned k = 1; k <= 16; k++) begin
      tv[k].nbin   = 3'b110;
      tv[k].bout   = (k == 12) ? 3'b001 : 3'b000;
      tv[k].blevel = (k >= 12) ? 3'b001 : 3'b000;
    end

    // Press on button 0 held from cycle 0: level and pulse at edge 12.
    do_reset();
    for (int unsigned k = 1; k <= 16; k++) begin
      nbin = tv[k].nbin;
      step();
      chk("t1_bout", bout, tv[k].bout);
      chk("t1_blevel", blevel, tv[k].blevel);
    end

    // Keep holding to edge 20, then release: level falls at edge 32, no pulse.
    while (ecyc < 20) begin
      step();
      chk("t1_hold_bout", bout, 3'b000);
    end
    nbin = 3'b111;
    while (ecyc < 40) begin
      step();
      chk("t3_bout", bout, 3'b000);
      chk("t3_blevel", blevel, (ecyc <= 31) ? 3'b001 : 3'b000);
    end

    // Glitch of 6 cycles on button 1 is rejected.
    do_reset();
    while (ecyc < 30) begin
      nbin = (ecyc < 6) ? 3'b101 : 3'b111;
      step();
      chk("t2_bout", bout, 3'b000);
      chk("t2_blevel", blevel, 3'b000);
    end

    // Long hold: repeat pulses only with AUTO_REPEAT_EN, then release.
    do_reset();
    nbin = 3'b110;
    while (ecyc < 70) begin
      step();
`ifdef AUTO_REPEAT_EN
      exp_b = (ecyc == 12 || ecyc == 44 || ecyc == 52 || ecyc == 60 || ecyc == 68) ? 3'b001 : 3'b000;
`else
      exp_b = (ecyc == 12) ? 3'b001 : 3'b000;
`endif
      chk("t4_bout", bout, exp_b);
    end
    nbin = 3'b111;
    while (ecyc < 110) begin
      step();
      if (ecyc >= 86) begin
        chk("t4_rel_bout", bout, 3'b000);
        chk("t4_rel_blevel", blevel, 3'b000);
      end
    end

    // All three pressed together, then reset while held.
    do_reset();
    nbin = 3'b000;
    while (ecyc < 15) begin
      step();
      chk("t5_bout", bout, (ecyc == 12) ? 3'b111 : 3'b000);
    end
    rst = 1'b1;
    step();
    chk("t5_rst_bout", bout, 3'b000);
    chk("t5_rst_blevel", blevel, 3'b000);
    step();
    rst = 1'b0;
    while (ecyc < 14) begin
      step();
      chk("t5_again_bout", bout, (ecyc == 12) ? 3'b111 : 3'b000);
      chk("t5_again_blevel", blevel, (ecyc >= 12) ? 3'b111 : 3'b000);
    end

    // Every-cycle toggling, phased so sampled values read released.
    do_reset();
    nbin = 3'b000;
    while (ecyc < 100) begin
      step();
      nbin = ~nbin;
      chk("t6_bout", bout, 3'b000);
      chk("t6_blevel", blevel, 3'b000);
    end

    // Randomized holds per button with occasional resets.
    do_reset();
    for (int unsigned i = 0; i < 3; i++) hold[i] = 0;
    rnd = 3'b111;
    for (int unsigned k = 0; k < 4000; k++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          rnd[i]  = $urandom_range(0, 1) != 0;
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                : int'($urandom_range(8, 80));
        end
        hold[i]--;
      end
      nbin = rnd;
      rst  = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
